// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronises rx_serial, samples each bit at mid-bit
// and presents each correctly framed byte with a one-cycle strobe.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing half a bit to re-check the start bit
// DATA  | sampling 8 data bits, one per CLK_PER_BIT
// STOP  | sampling the stop bit; strobe valid or frame error
module uart_rx #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_active
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, ferr_nxt;
  logic          rx_meta, rx_s, rx_prev;

  // Sync flops reset high so an idle line never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shift        <= shift_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (rx_prev && !rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_active = (state != IDLE);

endmodule
